// File: rtl/id_ex_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
// Optional bubble counter is enabled with ID_EX_BUBBLE_CNT_EN.
package id_ex_pkg;

  localparam int CTRL_W_DEF = 16;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        valid;
    logic        mem_read;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm32;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_ex_t;

endpackage

// File: rtl/imm_extender.sv
// Combinational 16-to-32 immediate extension (zero or sign).
// Feeds the ex_imm32 register in id_ex_stage_reg.
module imm_extender
  import id_ex_pkg::*;
(
  input  logic [15:0] imm16,
  input  logic        ext_sel,
  output logic [31:0] imm32
);

  always_comb begin
    imm32 = {16'h0000, imm16};
    unique case (ext_sel)
      EXT_SIGN: imm32 = {{16{imm16[15]}}, imm16};
      EXT_ZERO: imm32 = {16'h0000, imm16};
      default:  imm32 = {16'h0000, imm16};
    endcase
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall and bubble insertion.
// Define ID_EX_BUBBLE_CNT_EN to add the perf_bubble_cnt counter.
module id_ex_stage_reg
  import id_ex_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              id_valid,
  input  logic [31:0]       id_pc_plus4,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [15:0]       id_imm16,
  input  logic              id_ext_sel,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_mem_read,
  output logic [31:0]       ex_pc_plus4,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm32,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall_req
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  id_ex_t            ex_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [31:0]       imm_ext;
  logic              hz;
  logic              rt_match;

  imm_extender u_ext (
    .imm16   (id_imm16),
    .ext_sel (id_ext_sel),
    .imm32   (imm_ext)
  );

  // A load into $0 can never be a real producer.
  assign rt_match = (ex_q.rt == id_rs)
                  | (id_uses_rt & (ex_q.rt == id_rt));
  assign hz = ex_q.valid & ex_q.mem_read
            & (ex_q.rt != REG_ZERO)
            & id_valid & rt_match;
  assign stall_req = hz & ~flush;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ex_q   <= '0;
      ctrl_q <= '0;
    end else if (!hold) begin
      if (flush | hz) begin
        ex_q   <= '0;
        ctrl_q <= '0;
      end else begin
        ex_q.valid    <= id_valid;
        ex_q.mem_read <= id_valid & id_mem_read;
        ex_q.pc_plus4 <= id_pc_plus4;
        ex_q.rs_data  <= id_rs_data;
        ex_q.rt_data  <= id_rt_data;
        ex_q.imm32    <= imm_ext;
        ex_q.rs       <= id_rs;
        ex_q.rt       <= id_rt;
        ex_q.rd       <= id_rd;
        ctrl_q        <= id_valid ? id_ctrl : '0;
      end
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      perf_bubble_cnt <= '0;
    end else if (!hold && !flush && hz
                 && perf_bubble_cnt != 32'hFFFF_FFFF) begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

  assign ex_valid    = ex_q.valid;
  assign ex_mem_read = ex_q.mem_read;
  assign ex_pc_plus4 = ex_q.pc_plus4;
  assign ex_rs_data  = ex_q.rs_data;
  assign ex_rt_data  = ex_q.rt_data;
  assign ex_imm32    = ex_q.imm32;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_rd       = ex_q.rd;
  assign ex_ctrl     = ctrl_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_id_ex_stage_reg;
  import id_ex_pkg::*;

  localparam int CW = CTRL_W_DEF;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          id_valid;
  logic [31:0]   id_pc_plus4, id_rs_data, id_rt_data;
  logic [15:0]   id_imm16;
  logic          id_ext_sel;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          id_uses_rt, id_mem_read;
  logic [CW-1:0] id_ctrl;
  logic          hold, flush;
  logic          ex_valid, ex_mem_read;
  logic [31:0]   ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm32;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic [CW-1:0] ex_ctrl;
  logic          stall_req;
  logic [31:0]   perf_bubble_cnt;

  id_ex_stage_reg #(.CTRL_W(CW)) dut (
    .Clk(Clk), .Reset(Reset),
    .id_valid(id_valid), .id_pc_plus4(id_pc_plus4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm16(id_imm16), .id_ext_sel(id_ext_sel),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_mem_read(id_mem_read),
    .id_ctrl(id_ctrl), .hold(hold), .flush(flush),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm32(ex_imm32),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .stall_req(stall_req)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

`ifndef ID_EX_BUBBLE_CNT_EN
  assign perf_bubble_cnt = 32'd0;
`endif

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the EX-side contents
  logic          m_valid, m_mr;
  logic [31:0]   m_pc, m_rsd, m_rtd, m_imm, m_cnt;
  logic [4:0]    m_rs, m_rt, m_rd;
  logic [CW-1:0] m_ctrl;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_mr = 0; m_pc = 0; m_rsd = 0; m_rtd = 0;
    m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_ctrl = 0;
    m_cnt = 0;
  endtask

  function automatic logic model_hz();
    if (!(m_valid && m_mr && id_valid)) return 1'b0;
    if (m_rt == 5'd0) return 1'b0;
    if (m_rt == id_rs) return 1'b1;
    return id_uses_rt && (m_rt == id_rt);
  endfunction

  task automatic model_edge();
    logic h;
    logic [31:0] cnt;
    h = model_hz();
    if (hold) return;
    if (flush || h) begin
      cnt = m_cnt;
      model_reset();
      m_cnt = cnt;
      if (!flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      m_valid = id_valid;
      m_mr = id_valid && id_mem_read;
      m_pc = id_pc_plus4; m_rsd = id_rs_data; m_rtd = id_rt_data;
      m_imm = {16'h0, id_imm16};
      if (id_ext_sel && id_imm16 >= 16'h8000)
        m_imm = m_imm + 32'hFFFF_0000;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_ctrl = id_valid ? id_ctrl : '0;
    end
  endtask

  task automatic check_all();
    chk("ex_valid", 64'(ex_valid), 64'(m_valid));
    chk("ex_mem_read", 64'(ex_mem_read), 64'(m_mr));
    chk("ex_pc_plus4", 64'(ex_pc_plus4), 64'(m_pc));
    chk("ex_rs_data", 64'(ex_rs_data), 64'(m_rsd));
    chk("ex_rt_data", 64'(ex_rt_data), 64'(m_rtd));
    chk("ex_imm32", 64'(ex_imm32), 64'(m_imm));
    chk("ex_rs", 64'(ex_rs), 64'(m_rs));
    chk("ex_rt", 64'(ex_rt), 64'(m_rt));
    chk("ex_rd", 64'(ex_rd), 64'(m_rd));
    chk("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("perf_bubble_cnt", 64'(perf_bubble_cnt), 64'(m_cnt));
`endif
  endtask

  task automatic set_id(input logic v, input logic [15:0] imm,
                        input logic ext, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ur,
                        input logic mr, input logic [15:0] ctrl);
    id_valid = v; id_imm16 = imm; id_ext_sel = ext;
    id_rs = rs; id_rt = rt; id_rd = rs ^ rt;
    id_uses_rt = ur; id_mem_read = mr; id_ctrl = CW'(ctrl);
    id_pc_plus4 = $urandom; id_rs_data = $urandom;
    id_rt_data = $urandom;
  endtask

  // Inputs are applied at negedge; stall checked before the edge.
  task automatic cycle();
    #1 chk("stall_req", 64'(stall_req),
           64'(model_hz() && !flush));
    @(posedge Clk);
    model_edge();
    #1 check_all();
    @(negedge Clk);
  endtask

  typedef struct {
    logic v; logic [15:0] imm; logic ext;
    logic [4:0] rs, rt; logic ur, mr; logic [15:0] ctrl;
    logic e_stall, e_valid; logic [31:0] e_imm; logic [4:0] e_rs;
  } vec_t;

  vec_t tbl[6];
  logic [31:0] snap_pc, snap_rsd, cnt_before, new_pc;
  logic [CW-1:0] snap_ctrl;

  initial begin
    tbl[0] = '{1,16'h8001,0,1,2,1,0,16'h0001, 0,1,32'h0000_8001,1};
    tbl[1] = '{1,16'h8001,1,1,2,1,0,16'h0002, 0,1,32'hFFFF_8001,1};
    tbl[2] = '{1,16'h0004,1,29,8,0,1,16'h0003, 0,1,32'h0000_0004,29};
    tbl[3] = '{1,16'h0000,0,8,3,1,0,16'h0004, 1,0,32'h0,0};
    tbl[4] = '{1,16'h0000,0,8,3,1,0,16'h0004, 0,1,32'h0,8};
    tbl[5] = '{0,16'h7FFF,1,5,6,0,1,16'hFFFF, 0,0,32'h0000_7FFF,5};

    hold = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge Clk);
    check_all();
    chk("reset_stall", 64'(stall_req), 64'd0);
    Reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      set_id(tbl[i].v, tbl[i].imm, tbl[i].ext, tbl[i].rs,
             tbl[i].rt, tbl[i].ur, tbl[i].mr, tbl[i].ctrl);
      #1 chk($sformatf("vec%0d_stall", i), 64'(stall_req),
             64'(tbl[i].e_stall));
      @(posedge Clk);
      model_edge();
      #1;
      chk($sformatf("vec%0d_valid", i), 64'(ex_valid),
          64'(tbl[i].e_valid));
      chk($sformatf("vec%0d_imm", i), 64'(ex_imm32),
          64'(tbl[i].e_imm));
      chk($sformatf("vec%0d_rs", i), 64'(ex_rs),
          64'(tbl[i].e_rs));
      check_all();
      @(negedge Clk);
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("cnt_loaduse", 64'(perf_bubble_cnt), 64'd1);
`endif

    // Load into $0 followed by a reader of $0
    set_id(1, 0, 0, 3, 0, 0, 1, 16'h0010);
    cycle();
    set_id(1, 0, 0, 0, 0, 1, 0, 16'h0011);
    #1 chk("no_hz_r0", 64'(stall_req), 64'd0);
    cycle();

    // rt match without rt use, then flush colliding with hazard
    set_id(1, 0, 0, 3, 9, 0, 1, 16'h0020);
    cycle();
    set_id(1, 0, 0, 1, 9, 0, 0, 16'h0021);
    #1 chk("no_hz_rt_unused", 64'(stall_req), 64'd0);
    id_uses_rt = 1;
    #1 chk("hz_rt_used", 64'(stall_req), 64'd1);
    cnt_before = perf_bubble_cnt;
    flush = 1;
    #1 chk("flush_hz_stall", 64'(stall_req), 64'd0);
    @(posedge Clk);
    model_edge();
    #1 chk("flush_bubble", 64'(ex_valid), 64'd0);
    chk("flush_cnt", 64'(perf_bubble_cnt), 64'(cnt_before));
    check_all();
    @(negedge Clk);
    flush = 0;

    // Hold for three cycles while ID changes
    set_id(1, 16'h1234, 0, 4, 5, 1, 0, 16'h0030);
    cycle();
    snap_pc = ex_pc_plus4; snap_rsd = ex_rs_data;
    snap_ctrl = ex_ctrl;
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 16'(i), 1, 5'(i), 5'(i + 1), 1, 1, 16'h0040);
      cycle();
      chk("hold_pc", 64'(ex_pc_plus4), 64'(snap_pc));
      chk("hold_rsd", 64'(ex_rs_data), 64'(snap_rsd));
      chk("hold_ctrl", 64'(ex_ctrl), 64'(snap_ctrl));
    end
    hold = 0;
    set_id(1, 16'h00AA, 0, 6, 7, 1, 0, 16'h0050);
    new_pc = id_pc_plus4;
    cycle();
    chk("after_hold_pc", 64'(ex_pc_plus4), 64'(new_pc));

    // Reset while a load sits in EX with a dependent in ID
    set_id(1, 0, 0, 2, 12, 0, 1, 16'hFFFF);
    cycle();
    set_id(1, 0, 0, 12, 1, 1, 0, 16'h0060);
    #1 chk("pre_reset_stall", 64'(stall_req), 64'd1);
    Reset = 0;
    model_reset();
    #1 check_all();
    chk("reset_stall_drop", 64'(stall_req), 64'd0);
    Reset = 1;
    @(posedge Clk);
    model_edge();
    #1 check_all();
    @(negedge Clk);

    // Randomized traffic with narrow index range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      set_id(1'($urandom_range(0, 7) != 0), 16'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom_range(0, 2) != 0),
             16'($urandom));
      hold = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
